// File: rtl/gs_cfg_sequencer_pkg.sv
// Shared types and constants for the FPGA configuration / reset sequencer.
package gs_cfg_sequencer_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_NCFG  = 3'd0,
        ST_WSTAT = 3'd1,
        ST_WDONE = 3'd2,
        ST_WINIT = 3'd3,
        ST_WARM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

endpackage

// File: rtl/gs_cfg_sequencer_if.sv
// FPGA configuration pin bundle: nCONFIG out, nSTATUS/CONF_DONE/INIT_DONE back.
interface gs_cfg_sequencer_if;

    logic config_n;
    logic status_n;
    logic conf_done;
    logic init_done;

    modport master (output config_n, input status_n, input conf_done, input init_done);
    modport slave  (input config_n, output status_n, output conf_done, output init_done);

endinterface

// File: rtl/gs_cfg_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
module gs_sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/gs_cfg_sequencer.sv
// FPGA configuration sequencer with timeouts, bounded retries, warm-reset pulse and cold flag.
//
// state | meaning
// NCFG  | config_n held low for NCFG_LEN cycles
// WSTAT | config_n released, waiting for nSTATUS high
// WDONE | waiting for CONF_DONE (shares the WSTAT timeout window)
// WINIT | waiting for INIT_DONE
// WARM  | warmres_n held low for WARM_LEN cycles
// RUN   | FPGA configured, system out of reset
// FAIL  | retries exhausted; waits for cfg_restart or cold reset
module gs_cfg_sequencer
    import gs_cfg_sequencer_pkg::*;
#(
    parameter int CNT_W        = 24,
    parameter int NCFG_LEN     = 64,
    parameter int CFG_TIMEOUT  = 4000000,
    parameter int INIT_TIMEOUT = 4000,
    parameter int WARM_LEN     = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clkin,
    input  logic               coldres_n,
    input  logic               warmreq_n,
    input  logic               cfg_restart,
    input  logic               cold_clr,
    gs_cfg_sequencer_if.master fpga,
    output logic               warmres_n,
    output logic               fpga_ready,
    output logic               cfg_error,
    output logic               was_cold_n,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    generate
        if (longint'(NCFG_LEN) > CNT_MAX || longint'(CFG_TIMEOUT) > CNT_MAX ||
            longint'(INIT_TIMEOUT) > CNT_MAX || longint'(WARM_LEN) > CNT_MAX ||
            NCFG_LEN < 1 || CFG_TIMEOUT < 1 || INIT_TIMEOUT < 1 || WARM_LEN < 1) begin : g_bad_cnt_w
            $error("gs_cfg_sequencer: CNT_W too small for a cycle count parameter");
        end
        if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
            $error("gs_cfg_sequencer: MAX_RETRY must be 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0]   NCFG_LAST = CNT_W'(NCFG_LEN - 1);
    localparam logic [CNT_W-1:0]   CFG_LAST  = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   WARM_LAST = CNT_W'(WARM_LEN - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic warm_s, stat_s, done_s, init_s;
    logic warm_prev, warm_fall;

    gs_sync2 u_sync_warm (.clk(clkin), .d(warmreq_n),      .q(warm_s));
    gs_sync2 u_sync_stat (.clk(clkin), .d(fpga.status_n),  .q(stat_s));
    gs_sync2 u_sync_done (.clk(clkin), .d(fpga.conf_done), .q(done_s));
    gs_sync2 u_sync_init (.clk(clkin), .d(fpga.init_done), .q(init_s));

    assign warm_fall = warm_prev & ~warm_s;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   timer, timer_nx, timer_inc;
    logic [RETRY_W-1:0] retry_nx;
    logic               attempt_failed;
    logic               config_q;

    assign timer_inc     = (timer == {CNT_W{1'b1}}) ? timer : timer + CNT_W'(1);
    assign fpga.config_n = config_q;

    always_comb begin
        state_nx       = state;
        timer_nx       = timer_inc;
        retry_nx       = retry_cnt;
        attempt_failed = 1'b0;

        case (state)
            ST_NCFG: begin
                if (timer == NCFG_LAST) begin
                    state_nx = ST_WSTAT;
                    timer_nx = '0;
                end
            end
            // No timer clear on WSTAT->WDONE: one window covers both waits.
            ST_WSTAT: begin
                if (stat_s)                  state_nx = ST_WDONE;
                else if (timer >= CFG_LAST)  attempt_failed = 1'b1;
            end
            ST_WDONE: begin
                if (done_s) begin
                    state_nx = ST_WINIT;
                    timer_nx = '0;
                end else if (!stat_s || timer >= CFG_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            ST_WINIT: begin
                if (init_s) begin
                    state_nx = ST_WARM;
                    timer_nx = '0;
                end else if (!stat_s || timer >= INIT_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            ST_WARM: begin
                if (warm_fall) begin
                    timer_nx = '0;
                end else if (timer == WARM_LAST) begin
                    state_nx = ST_RUN;
                    timer_nx = '0;
                end
            end
            ST_RUN: begin
                if (!stat_s || !done_s) begin
                    state_nx = ST_NCFG;
                    timer_nx = '0;
                    retry_nx = '0;
                end else if (warm_fall) begin
                    state_nx = ST_WARM;
                    timer_nx = '0;
                end
            end
            ST_FAIL: state_nx = ST_FAIL;
            default: begin
                state_nx = ST_NCFG;
                timer_nx = '0;
            end
        endcase

        if (attempt_failed) begin
            timer_nx = '0;
            if (retry_cnt == RETRY_LAST) begin
                state_nx = ST_FAIL;
            end else begin
                state_nx = ST_NCFG;
                retry_nx = retry_cnt + RETRY_W'(1);
            end
        end

        if (cfg_restart) begin
            state_nx = ST_NCFG;
            timer_nx = '0;
            retry_nx = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            state      <= ST_NCFG;
            timer      <= '0;
            retry_cnt  <= '0;
            config_q   <= 1'b0;
            warmres_n  <= 1'b0;
            fpga_ready <= 1'b0;
            cfg_error  <= 1'b0;
            was_cold_n <= 1'b0;
            warm_prev  <= 1'b1;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            retry_cnt  <= retry_nx;
            config_q   <= (state_nx != ST_NCFG);
            warmres_n  <= (state_nx == ST_RUN);
            fpga_ready <= (state_nx == ST_RUN);
            cfg_error  <= (state_nx == ST_FAIL);
            warm_prev  <= warm_s;
            if (cold_clr) was_cold_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gs_cfg_sequencer.sv
// Directed bench for gs_cfg_sequencer: cold boot, retries/FAIL, warm pulse, config loss, cold flag.
module tb_gs_cfg_sequencer;

    logic       clkin = 1'b0;
    logic       coldres_n, warmreq_n, cfg_restart, cold_clr;
    logic       warmres_n, fpga_ready, cfg_error, was_cold_n;
    logic [3:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int n, n1, rdy_bad;

    gs_cfg_sequencer_if fif ();

    gs_cfg_sequencer #(
        .CNT_W(8), .NCFG_LEN(4), .CFG_TIMEOUT(32), .INIT_TIMEOUT(16), .WARM_LEN(8), .MAX_RETRY(2)
    ) dut (
        .clkin(clkin), .coldres_n(coldres_n), .warmreq_n(warmreq_n), .cfg_restart(cfg_restart),
        .cold_clr(cold_clr), .fpga(fif), .warmres_n(warmres_n), .fpga_ready(fpga_ready),
        .cfg_error(cfg_error), .was_cold_n(was_cold_n), .retry_cnt(retry_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        coldres_n = 1'b0; warmreq_n = 1'b1; cfg_restart = 1'b0; cold_clr = 1'b0;
        fif.status_n = 1'b0; fif.conf_done = 1'b0; fif.init_done = 1'b0;

        // 1: cold boot
        repeat (5) tick();
        chk("rst_config_n", fif.config_n, 0);
        chk("rst_warmres_n", warmres_n, 0);
        chk("rst_ready", fpga_ready, 0);
        chk("rst_error", cfg_error, 0);
        chk("rst_was_cold_n", was_cold_n, 0);
        chk("rst_retry", retry_cnt, 0);
        coldres_n = 1'b1;
        n = 0;
        while (fif.config_n !== 1'b1 && n < 20) begin tick(); n++; end
        chk("boot_ncfg_len", n, 4);
        fif.status_n = 1'b1;
        repeat (10) tick();
        fif.conf_done = 1'b1;
        repeat (3) tick();
        fif.init_done = 1'b1;
        // 2 sync edges + 1 to enter WARM, then 8 WARM cycles
        n = 0;
        while (fpga_ready !== 1'b1 && n < 40) begin tick(); n++; end
        chk("boot_to_run", n, 11);
        chk("boot_warmres_n", warmres_n, 1);
        chk("boot_config_n", fif.config_n, 1);
        chk("boot_was_cold_n", was_cold_n, 0);
        chk("boot_retry", retry_cnt, 0);

        // 4: warm request, second edge 3 cycles into WARM stretches the pulse
        warmreq_n = 1'b0;
        tick();
        warmreq_n = 1'b1;
        tick();
        chk("warm_sync_lat", fpga_ready, 1);
        tick();
        chk("warm_entry_warmres", warmres_n, 0);
        chk("warm_entry_ready", fpga_ready, 0);
        warmreq_n = 1'b0;
        n = 0; rdy_bad = 0;
        while (warmres_n !== 1'b1 && n < 40) begin
            tick(); n++;
            if (warmres_n === 1'b0 && fpga_ready !== 1'b0) rdy_bad = 1;
        end
        chk("warm_ext_len", n, 11);
        chk("warm_ready_low", rdy_bad, 0);
        chk("warm_back_run", fpga_ready, 1);
        warmreq_n = 1'b1;
        repeat (3) tick();

        // 5: FPGA loses its configuration in RUN
        fif.conf_done = 1'b0;
        tick();
        tick();
        chk("lost_sync_lat", fif.config_n, 1);
        tick();
        chk("lost_config_n", fif.config_n, 0);
        chk("lost_ready", fpga_ready, 0);
        chk("lost_retry", retry_cnt, 0);
        n = 0;
        while (fif.config_n !== 1'b1 && n < 20) begin tick(); n++; end
        chk("lost_ncfg_len", n, 4);

        // 3: nSTATUS pulse in WDONE on the first attempt, second attempt good
        repeat (3) tick();
        fif.status_n = 1'b0;
        tick();
        fif.status_n = 1'b1;
        n = 0;
        while (retry_cnt !== 4'd1 && n < 10) begin tick(); n++; end
        chk("stat_err_lat", n, 2);
        chk("stat_err_ncfg", fif.config_n, 0);
        fif.conf_done = 1'b1;
        n = 0;
        while (fpga_ready !== 1'b1 && n < 80) begin tick(); n++; end
        chk("retry_run_ready", fpga_ready, 1);
        chk("retry_run_cnt", retry_cnt, 1);
        chk("retry_run_error", cfg_error, 0);

        // 2: conf_done never rises; each attempt is 4 NCFG + 32 timeout edges
        fif.conf_done = 1'b0;
        fif.init_done = 1'b0;
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        chk("restart_config_n", fif.config_n, 0);
        chk("restart_retry", retry_cnt, 0);
        chk("restart_ready", fpga_ready, 0);
        n = 0; n1 = -1;
        while (cfg_error !== 1'b1 && n < 200) begin
            tick(); n++;
            if (n1 < 0 && retry_cnt === 4'd1) n1 = n;
        end
        chk("tmo_first_retry", n1, 36);
        chk("tmo_to_fail", n, 72);
        chk("fail_warmres_n", warmres_n, 0);
        chk("fail_config_n", fif.config_n, 1);
        chk("fail_ready", fpga_ready, 0);
        chk("fail_retry", retry_cnt, 1);
        repeat (10) tick();
        chk("fail_sticky", cfg_error, 1);
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        chk("fail_restart_err", cfg_error, 0);
        chk("fail_restart_cfg", fif.config_n, 0);
        chk("fail_restart_retry", retry_cnt, 0);

        // 6: cold flag handling
        chk("cold_before_clr", was_cold_n, 0);
        cold_clr = 1'b1;
        coldres_n = 1'b0;
        tick();
        cold_clr = 1'b0;
        chk("clr_vs_reset", was_cold_n, 0);
        tick();
        coldres_n = 1'b1;
        tick();
        chk("cold_after_rst", was_cold_n, 0);
        cold_clr = 1'b1;
        tick();
        cold_clr = 1'b0;
        chk("cold_clr", was_cold_n, 1);
        repeat (2) tick();
        chk("cold_clr_hold", was_cold_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
